stereo_write_scheduler: RTL and testbench

- Round-robin arbiter and sequencer that shares one frame-buffer write port between the left and right camera pixel streams of the two-video-path design.
- Each stream gets its own linear pixel-address counter, which wraps at one frame.
- The block runs one frame pass per start pulse and signals when both streams have written a full frame.
- Sits between the per-camera pixel pipelines and the dual-frame BRAM writer.

---
 rtl/stereo_write_scheduler_if.sv | 29 ++
 rtl/stereo_write_scheduler.sv | 135 +++++++++++++
 tb/tb_stereo_write_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/stereo_write_scheduler_if.sv
// Handshake bundle between the two camera pixel streams, the scheduler and the
// frame-buffer write port.
interface stereo_write_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 16
);
  logic                  l_valid_in;
  logic [DATA_WIDTH-1:0] l_data_in;
  logic                  l_ready_out;
  logic                  r_valid_in;
  logic [DATA_WIDTH-1:0] r_data_in;
  logic                  r_ready_out;
  logic                  wr_valid_out;
  logic                  wr_ready_in;
  logic [DATA_WIDTH-1:0] wr_data_out;
  logic [AW-1:0]         wr_addr_out;
  logic                  wr_side_out;

  // Scheduler view: consumes both pixel streams, drives the write port.
  modport master (
    input  l_valid_in, l_data_in, r_valid_in, r_data_in, wr_ready_in,
    output l_ready_out, r_ready_out, wr_valid_out, wr_data_out, wr_addr_out, wr_side_out
  );

  modport slave (
    output l_valid_in, l_data_in, r_valid_in, r_data_in, wr_ready_in,
    input  l_ready_out, r_ready_out, wr_valid_out, wr_data_out, wr_addr_out, wr_side_out
  );
endinterface

// File: rtl/stereo_write_scheduler.sv
// Round-robin scheduler sharing one frame-buffer write port between the left and
// right camera streams; one frame pass per start pulse.
module stereo_write_scheduler #(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 180,
  parameter int DATA_WIDTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  stereo_write_scheduler_if.master bus_if,
  output logic                     busy_out,
  output logic                     frame_done_out
);
  localparam int NPIX = H_ACTIVE * V_ACTIVE;
  localparam int AW   = $clog2(NPIX);
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic {SIDE_L = 1'b0, SIDE_R = 1'b1} side_e;

  state_e                state_q, state_d;
  side_e                 rr_q, rr_d;
  logic [AW-1:0]         l_cnt_q, l_cnt_d, r_cnt_q, r_cnt_d;
  logic                  l_done_q, l_done_d, r_done_q, r_done_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [AW-1:0]         out_addr_q, out_addr_d;
  side_e                 out_side_q, out_side_d;

  logic slot_free, l_elig, r_elig, grant_l, grant_r;

  // A new beat may be loaded when the output register is empty or draining now.
  assign slot_free = !out_valid_q || bus_if.wr_ready_in;
  assign l_elig    = (state_q == S_RUN) && bus_if.l_valid_in && !l_done_q && slot_free;
  assign r_elig    = (state_q == S_RUN) && bus_if.r_valid_in && !r_done_q && slot_free;
  assign grant_l   = l_elig && (!r_elig || rr_q == SIDE_L);
  assign grant_r   = r_elig && (!l_elig || rr_q == SIDE_R);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    rr_d        = rr_q;
    l_cnt_d     = l_cnt_q;
    r_cnt_d     = r_cnt_q;
    l_done_d    = l_done_q;
    r_done_d    = r_done_q;
    out_valid_d = out_valid_q && !bus_if.wr_ready_in;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_side_d  = out_side_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d  = S_RUN;
          rr_d     = SIDE_L;
          l_cnt_d  = '0;
          r_cnt_d  = '0;
          l_done_d = 1'b0;
          r_done_d = 1'b0;
        end
      end
      S_RUN: begin
        if (grant_l) begin
          out_valid_d = 1'b1;
          out_data_d  = bus_if.l_data_in;
          out_addr_d  = l_cnt_q;
          out_side_d  = SIDE_L;
          rr_d        = SIDE_R;
          if (l_cnt_q == LAST_PIX) begin
            l_cnt_d  = '0;
            l_done_d = 1'b1;
          end else begin
            l_cnt_d = l_cnt_q + 1'b1;
          end
        end else if (grant_r) begin
          out_valid_d = 1'b1;
          out_data_d  = bus_if.r_data_in;
          out_addr_d  = r_cnt_q;
          out_side_d  = SIDE_R;
          rr_d        = SIDE_L;
          if (r_cnt_q == LAST_PIX) begin
            r_cnt_d  = '0;
            r_done_d = 1'b1;
          end else begin
            r_cnt_d = r_cnt_q + 1'b1;
          end
        end
        // Finish only once the final beat has left the output register.
        if (l_done_q && r_done_q && slot_free) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      rr_q        <= SIDE_L;
      l_cnt_q     <= '0;
      r_cnt_q     <= '0;
      l_done_q    <= 1'b0;
      r_done_q    <= 1'b0;
      out_valid_q <= 1'b0;
      // NOTE: the datapath registers are reset too because they drive ports that must read 0.
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_side_q  <= SIDE_L;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      l_cnt_q     <= l_cnt_d;
      r_cnt_q     <= r_cnt_d;
      l_done_q    <= l_done_d;
      r_done_q    <= r_done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_side_q  <= out_side_d;
    end
  end

  assign bus_if.l_ready_out  = grant_l;
  assign bus_if.r_ready_out  = grant_r;
  assign bus_if.wr_valid_out = out_valid_q;
  assign bus_if.wr_data_out  = out_data_q;
  assign bus_if.wr_addr_out  = out_addr_q;
  assign bus_if.wr_side_out  = out_side_q;
  assign busy_out            = (state_q != S_IDLE);
  assign frame_done_out      = (state_q == S_DONE);

endmodule

// File: tb/tb_stereo_write_scheduler.sv
// Randomized scoreboard bench for stereo_write_scheduler on a 4x2 frame: a
// pass-level model predicts grants and write beats, a monitor checks the write port.
module tb_stereo_write_scheduler;
  localparam int H    = 4;
  localparam int V    = 2;
  localparam int DW   = 16;
  localparam int NPIX = H * V;
  localparam int AW   = $clog2(NPIX);

  logic clk_in = 1'b0;
  logic rst_in;
  logic start_in;
  logic busy_out;
  logic frame_done_out;

  stereo_write_scheduler_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

  stereo_write_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(DW)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .bus_if         (bus),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          side;
    int            addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];

  // Pass-level reference: how many pixels each side has written, whether each
  // side has finished its frame, who wins a tie next, and whether a beat is parked.
  typedef enum {PH_IDLE, PH_RUN, PH_DONE} phase_e;
  phase_e phase   = PH_IDLE;
  int     written[2] = '{0, 0};
  bit     fin[2]     = '{1'b0, 1'b0};
  int     prefer  = 0;
  bit     held    = 1'b0;
  bit     m_take, m_want_l, m_want_r, m_both, m_drain;
  int     m_grant;
  beat_t  m_beat;

  always @(negedge clk_in) begin
    #1;
    m_take   = (phase == PH_RUN) && (!held || bus.wr_ready_in);
    m_want_l = m_take && bus.l_valid_in && !fin[0];
    m_want_r = m_take && bus.r_valid_in && !fin[1];
    if (m_want_l && m_want_r) m_grant = prefer;
    else if (m_want_l)        m_grant = 0;
    else if (m_want_r)        m_grant = 1;
    else                      m_grant = -1;

    check("l_ready", 32'(bus.l_ready_out), 32'(m_grant == 0));
    check("r_ready", 32'(bus.r_ready_out), 32'(m_grant == 1));
    check("busy", 32'(busy_out), 32'(phase != PH_IDLE));
    check("frame_done", 32'(frame_done_out), 32'(phase == PH_DONE));

    if (!rst_in) begin
      phase   = PH_IDLE;
      held    = 1'b0;
      prefer  = 0;
      written = '{0, 0};
      fin     = '{1'b0, 1'b0};
      exp_q.delete();
    end else begin
      case (phase)
        PH_IDLE: begin
          if (start_in) begin
            phase   = PH_RUN;
            prefer  = 0;
            written = '{0, 0};
            fin     = '{1'b0, 1'b0};
          end
        end
        PH_RUN: begin
          m_both  = fin[0] && fin[1];
          m_drain = !held || bus.wr_ready_in;
          if (m_grant >= 0) begin
            m_beat.side = m_grant[0];
            m_beat.addr = written[m_grant];
            m_beat.data = (m_grant == 0) ? bus.l_data_in : bus.r_data_in;
            exp_q.push_back(m_beat);
            written[m_grant]++;
            if (written[m_grant] == NPIX) fin[m_grant] = 1'b1;
            prefer = 1 - m_grant;
            held   = 1'b1;
          end else if (bus.wr_ready_in) begin
            held = 1'b0;
          end
          if (m_both && m_drain) phase = PH_DONE;
        end
        default: phase = PH_IDLE;
      endcase
    end
  end

  // Monitor: every presented beat must match the oldest expected one; it is
  // retired only when the write port accepts it, so a stalled beat is re-checked.
  always @(negedge clk_in) begin
    if (bus.wr_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got side=%0d addr=%0d data=0x%0h, expected no beat at %0t",
                 bus.wr_side_out, bus.wr_addr_out, bus.wr_data_out, $time);
      end else begin
        check("wr_side", 32'(bus.wr_side_out), 32'(exp_q[0].side));
        check("wr_addr", 32'(bus.wr_addr_out), 32'(exp_q[0].addr));
        check("wr_data", 32'(bus.wr_data_out), 32'(exp_q[0].data));
        if (bus.wr_ready_in) void'(exp_q.pop_front());
      end
    end
  end

  // One stimulus cycle per iteration, with per-input probabilities in percent.
  task automatic drive(input int n, input int lp, input int rp, input int wp, input int sp);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      bus.l_valid_in  = ($urandom_range(99) < lp);
      bus.r_valid_in  = ($urandom_range(99) < rp);
      bus.l_data_in   = DW'($urandom);
      bus.r_data_in   = DW'($urandom);
      bus.wr_ready_in = ($urandom_range(99) < wp);
      start_in        = ($urandom_range(99) < sp);
    end
  endtask

  task automatic pulse_start();
    drive(1, 0, 0, 100, 100);
  endtask

  initial begin
    rst_in          = 1'b0;
    start_in        = 1'b0;
    bus.l_valid_in  = 1'b0;
    bus.r_valid_in  = 1'b0;
    bus.l_data_in   = '0;
    bus.r_data_in   = '0;
    bus.wr_ready_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_wr_valid", 32'(bus.wr_valid_out), 32'd0);
    check("reset_wr_addr", 32'(bus.wr_addr_out), 32'd0);
    check("reset_wr_data", 32'(bus.wr_data_out), 32'd0);
    check("reset_wr_side", 32'(bus.wr_side_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;

    // Left stream alone, then right stream alone, then let the pass finish.
    pulse_start();
    drive(12, 100, 0, 100, 0);
    drive(12, 0, 100, 100, 0);
    drive(4, 0, 0, 100, 0);

    // Both streams saturated: strict alternation starting with left.
    pulse_start();
    drive(22, 100, 100, 100, 0);

    // Write-port stall mid-frame.
    pulse_start();
    drive(4, 100, 100, 100, 0);
    drive(5, 100, 100, 0, 0);
    drive(22, 100, 100, 100, 0);

    // Reset after three beats, then a fresh pass from address 0.
    pulse_start();
    drive(3, 100, 100, 100, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    check("post_reset_wr_valid", 32'(bus.wr_valid_out), 32'd0);
    check("post_reset_busy", 32'(busy_out), 32'd0);
    pulse_start();
    drive(22, 100, 100, 100, 0);

    // start held high through RUN and DONE; it may only relaunch from IDLE.
    pulse_start();
    drive(24, 100, 100, 100, 100);

    // Random traffic, back-pressure and stray start pulses.
    drive(600, 70, 70, 60, 10);
    drive(40, 100, 100, 100, 0);
    drive(4, 0, 0, 100, 0);
    @(negedge clk_in);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(busy_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
